// File: rtl/video_out.sv
// Pixel output stage: registers the framebuffer byte, maps it through a
// CPU-writable RGB444 palette, applies blanking and keeps sync aligned with colour.
module video_out #(
    parameter int PAL_ENTRIES = 256,
    parameter int CH_BITS     = 4
) (
    input  logic               PxClock,
    input  logic               Reset_n,
    input  logic [7:0]         PixelIn,
    input  logic               HBlank,
    input  logic               VBlank,
    input  logic               HSync,
    input  logic               VSync,
    input  logic               BlankBlack,
    input  logic               BlankWhite,
    input  logic               PalWe,
    input  logic               PalSel,
    input  logic [7:0]         PalData,
    output logic [CH_BITS-1:0] Red,
    output logic [CH_BITS-1:0] Green,
    output logic [CH_BITS-1:0] Blue,
    output logic               HSyncOut,
    output logic               VSyncOut,
    output logic               BlankOut
);

    typedef struct packed {
        logic [7:0] pix;
        logic       hblank;
        logic       vblank;
        logic       hsync;
        logic       vsync;
        logic       bblack;
        logic       bwhite;
    } s1_t;

    typedef struct packed {
        logic [CH_BITS-1:0] r;
        logic [CH_BITS-1:0] g;
        logic [CH_BITS-1:0] b;
    } rgb_t;

    // Reset palette spreads the pixel byte as RGB332 across the 4-bit channels.
    function automatic rgb_t pal_default(input logic [7:0] i);
        rgb_t c;
        c.r = {i[7:5], i[7]};
        c.g = {i[4:2], i[4]};
        c.b = {i[1:0], i[1:0]};
        return c;
    endfunction

    s1_t        s1_q, s1_d;
    rgb_t       pal_q [PAL_ENTRIES];
    logic [7:0] idx_q, idx_d;
    logic       phase_q, phase_d;
    logic [3:0] red_q, red_d;
    logic       commit;

    rgb_t       col_q, col_d;
    logic       blank_q, blank_d;
    logic       hs_q, vs_q;

    always_comb begin
        s1_d.pix    = PixelIn;
        s1_d.hblank = HBlank;
        s1_d.vblank = VBlank;
        s1_d.hsync  = HSync;
        s1_d.vsync  = VSync;
        s1_d.bblack = BlankBlack;
        s1_d.bwhite = BlankWhite;
    end

    // CPU write port: index write, then red, then green/blue commits the entry.
    always_comb begin
        idx_d   = idx_q;
        phase_d = phase_q;
        red_d   = red_q;
        commit  = 1'b0;
        if (PalWe) begin
            if (!PalSel) begin
                idx_d   = PalData;
                phase_d = 1'b0;
                red_d   = '0;
            end else if (!phase_q) begin
                red_d   = PalData[3:0];
                phase_d = 1'b1;
            end else begin
                commit  = 1'b1;
                idx_d   = idx_q + 8'd1;
                phase_d = 1'b0;
            end
        end
    end

    always_ff @(posedge PxClock or negedge Reset_n) begin
        if (!Reset_n) begin
            idx_q   <= '0;
            phase_q <= 1'b0;
            red_q   <= '0;
        end else begin
            idx_q   <= idx_d;
            phase_q <= phase_d;
            red_q   <= red_d;
        end
    end

    always_ff @(posedge PxClock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < PAL_ENTRIES; i++) begin
                pal_q[i] <= pal_default(8'(i));
            end
        end else if (commit) begin
            pal_q[idx_q] <= '{r: red_q, g: PalData[7:4], b: PalData[3:0]};
        end
    end

    // Lookup reads the registered palette, so a same-edge commit is seen one pixel later.
    always_comb begin
        blank_d = s1_q.hblank | s1_q.vblank;
        col_d   = pal_q[s1_q.pix];
        if (blank_d || s1_q.bblack) begin
            col_d = '0;
        end else if (s1_q.bwhite) begin
            col_d = '1;
        end
    end

    always_ff @(posedge PxClock or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_q    <= '0;
            col_q   <= '0;
            blank_q <= 1'b0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            col_q   <= col_d;
            blank_q <= blank_d;
            hs_q    <= s1_q.hsync;
            vs_q    <= s1_q.vsync;
        end
    end

    assign Red      = col_q.r;
    assign Green    = col_q.g;
    assign Blue     = col_q.b;
    assign HSyncOut = hs_q;
    assign VSyncOut = vs_q;
    assign BlankOut = blank_q;

endmodule
